// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// ValidReg bit positions, the x0 index and the bundled control vector.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_BUSY = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam int VR_RD  = 0;
  localparam int VR_RS1 = 1;
  localparam int VR_RS2 = 2;

  localparam logic [4:0] REG_X0 = 5'd0;

  // One field per pipeline control output, so the FSM can clear them all at once.
  typedef struct packed {
    logic if_stall;
    logic id_stall;
    logic ex_stall;
    logic mem_stall;
    logic ex_bubble;
    logic mem_bubble;
    logic wb_bubble;
    logic if_id_flush;
    logic id_ex_flush;
    logic mdu_start;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms: load-use between EX and ID, and data-memory wait.
// Kept separate so trace/debug logic can observe the same terms.
module hazard_detect
  import hazard_controller_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_rs1_vld,
  input  logic       i_id_rs2_vld,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_rd_vld,
  input  logic       i_ex_is_load,
  input  logic       i_mem_dmem_req,
  input  logic       i_dmem_ready,
  output logic       o_load_use,
  output logic       o_mem_wait
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_rs1_vld && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_rs2_vld && (i_id_rs2 == i_ex_rd);

  // A load to x0 produces nothing to wait for.
  assign o_load_use = i_ex_is_load && i_ex_rd_vld && (i_ex_rd != REG_X0) &&
                      (w_rs1_hit || w_rs2_hit);

  assign o_mem_wait = i_mem_dmem_req && !i_dmem_ready;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: resolves hazards forwarding cannot cover,
// drives stage stall/flush/bubble controls, MDU launch, watchdog and stall counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [2:0]       ID_ValidReg,
  input  logic [4:0]       EX_rd,
  input  logic [2:0]       EX_ValidReg,
  input  logic             EX_is_load,
  input  logic             EX_is_mdu,
  input  logic             EX_branch_taken,
  input  logic             mdu_done,
  input  logic             MEM_dmem_req,
  input  logic             dmem_ready,
  output logic             IF_stall,
  output logic             ID_stall,
  output logic             EX_stall,
  output logic             MEM_stall,
  output logic             EX_bubble,
  output logic             MEM_bubble,
  output logic             WB_bubble,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             mdu_start,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MDU_TIMEOUT);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_done_q;
  logic             r_ret_mdu;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cycles;

  ctrl_t w_ctrl;
  logic  w_load_use;
  logic  w_mem_wait;
  logic  w_done_any;
  logic  w_done_set;
  logic  w_done_clr;
  logic  w_wd_clr;
  logic  w_wd_inc;
  logic  w_unused;

  hazard_detect u_hazard_detect (
    .i_id_rs1       (ID_rs1),
    .i_id_rs2       (ID_rs2),
    .i_id_rs1_vld   (ID_ValidReg[VR_RS1]),
    .i_id_rs2_vld   (ID_ValidReg[VR_RS2]),
    .i_ex_rd        (EX_rd),
    .i_ex_rd_vld    (EX_ValidReg[VR_RD]),
    .i_ex_is_load   (EX_is_load),
    .i_mem_dmem_req (MEM_dmem_req),
    .i_dmem_ready   (dmem_ready),
    .o_load_use     (w_load_use),
    .o_mem_wait     (w_mem_wait)
  );

  // ID's rd bit and EX's source bits play no part in hazard detection.
  assign w_unused   = ^{ID_ValidReg[VR_RD], EX_ValidReg[VR_RS2:VR_RS1]};
  assign w_done_any = mdu_done || r_done_q;

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    w_ctrl       = CTRL_IDLE;
    w_state_next = r_state;
    w_done_set   = 1'b0;
    w_done_clr   = 1'b0;
    w_wd_clr     = 1'b0;
    w_wd_inc     = 1'b0;

    if (w_mem_wait) begin
      // Memory wait freezes everything up to MEM; the MDU keeps computing.
      w_ctrl.if_stall  = 1'b1;
      w_ctrl.id_stall  = 1'b1;
      w_ctrl.ex_stall  = 1'b1;
      w_ctrl.mem_stall = 1'b1;
      w_ctrl.wb_bubble = 1'b1;
      w_done_set       = mdu_done;
      if (r_state == ST_RUN) w_state_next = ST_MEM_WAIT;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (EX_is_mdu && EX_ValidReg[VR_RD]) begin
            w_ctrl.mdu_start  = 1'b1;
            w_ctrl.if_stall   = 1'b1;
            w_ctrl.id_stall   = 1'b1;
            w_ctrl.ex_stall   = 1'b1;
            w_ctrl.mem_bubble = 1'b1;
            w_wd_clr          = 1'b1;
            w_state_next      = ST_MDU_BUSY;
          end else if (EX_branch_taken) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            w_ctrl.if_stall  = 1'b1;
            w_ctrl.id_stall  = 1'b1;
            w_ctrl.ex_bubble = 1'b1;
          end
        end
        ST_MDU_BUSY: begin
          if (w_done_any) begin
            w_done_clr   = 1'b1;
            w_state_next = ST_RUN;
          end else begin
            w_ctrl.if_stall   = 1'b1;
            w_ctrl.id_stall   = 1'b1;
            w_ctrl.ex_stall   = 1'b1;
            w_ctrl.mem_bubble = 1'b1;
            w_wd_inc          = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          w_done_set   = mdu_done && r_ret_mdu;
          w_state_next = r_ret_mdu ? ST_MDU_BUSY : ST_RUN;
        end
        default: w_state_next = ST_RUN;
      endcase
    end

    if (rst) w_ctrl = CTRL_IDLE;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  // NOTE: every register, counters included, is cleared by reset; none holds data
  // that could be left uninitialised.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_done_q       <= 1'b0;
      r_ret_mdu      <= 1'b0;
      r_wd_cnt       <= '0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_done_clr)      r_done_q <= 1'b0;
      else if (w_done_set) r_done_q <= 1'b1;

      if (r_state != ST_MEM_WAIT && w_state_next == ST_MEM_WAIT)
        r_ret_mdu <= (r_state == ST_MDU_BUSY);

      // Watchdog parks at its limit; the flag is sticky until reset.
      if (w_wd_clr) begin
        r_wd_cnt <= '0;
      end else if (w_wd_inc && r_wd_cnt != WD_MAX) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
        if (r_wd_cnt == WD_LAST) r_timeout <= 1'b1;
      end

      if (w_ctrl.if_stall && r_stall_cycles != '1)
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign IF_stall     = w_ctrl.if_stall;
  assign ID_stall     = w_ctrl.id_stall;
  assign EX_stall     = w_ctrl.ex_stall;
  assign MEM_stall    = w_ctrl.mem_stall;
  assign EX_bubble    = w_ctrl.ex_bubble;
  assign MEM_bubble   = w_ctrl.mem_bubble;
  assign WB_bubble    = w_ctrl.wb_bubble;
  assign IF_ID_flush  = w_ctrl.if_id_flush;
  assign ID_EX_flush  = w_ctrl.id_ex_flush;
  assign mdu_start    = w_ctrl.mdu_start;
  assign mdu_timeout  = r_timeout;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller: load-use, MDU, memory wait,
// branch priority, watchdog, reset and counter saturation.
module tb_hazard_controller;

  localparam int CNT_W       = 4;
  localparam int MDU_TIMEOUT = 8;

  // Control vector order: IF ID EX MEM stall, EX MEM WB bubble, IF_ID ID_EX flush, start.
  localparam logic [9:0] C_NONE  = 10'b0000000000;
  localparam logic [9:0] C_LU    = 10'b1100100000;
  localparam logic [9:0] C_HOLD  = 10'b1110010000;
  localparam logic [9:0] C_START = 10'b1110010001;
  localparam logic [9:0] C_MEMW  = 10'b1111001000;
  localparam logic [9:0] C_BR    = 10'b0000000110;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       ID_rs1, ID_rs2, EX_rd;
  logic [2:0]       ID_ValidReg, EX_ValidReg;
  logic             EX_is_load, EX_is_mdu, EX_branch_taken;
  logic             mdu_done, MEM_dmem_req, dmem_ready;
  logic             IF_stall, ID_stall, EX_stall, MEM_stall;
  logic             EX_bubble, MEM_bubble, WB_bubble;
  logic             IF_ID_flush, ID_EX_flush, mdu_start, mdu_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [9:0]       ctrl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_controller #(.CNT_W(CNT_W), .MDU_TIMEOUT(MDU_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_ValidReg(ID_ValidReg),
    .EX_rd(EX_rd), .EX_ValidReg(EX_ValidReg), .EX_is_load(EX_is_load),
    .EX_is_mdu(EX_is_mdu), .EX_branch_taken(EX_branch_taken), .mdu_done(mdu_done),
    .MEM_dmem_req(MEM_dmem_req), .dmem_ready(dmem_ready),
    .IF_stall(IF_stall), .ID_stall(ID_stall), .EX_stall(EX_stall), .MEM_stall(MEM_stall),
    .EX_bubble(EX_bubble), .MEM_bubble(MEM_bubble), .WB_bubble(WB_bubble),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .mdu_start(mdu_start),
    .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles)
  );

  assign ctrl = {IF_stall, ID_stall, EX_stall, MEM_stall, EX_bubble, MEM_bubble,
                 WB_bubble, IF_ID_flush, ID_EX_flush, mdu_start};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_idle();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_ValidReg = 3'b000;
    EX_rd = 5'd0; EX_ValidReg = 3'b000;
    EX_is_load = 1'b0; EX_is_mdu = 1'b0; EX_branch_taken = 1'b0;
    mdu_done = 1'b0; MEM_dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] id_vr);
    EX_is_load = 1'b1; EX_ValidReg = 3'b001; EX_rd = rd;
    ID_rs1 = rs1; ID_rs2 = rs2; ID_ValidReg = id_vr;
  endtask

  task automatic set_mul();
    EX_is_mdu = 1'b1; EX_ValidReg = 3'b111; EX_rd = 5'd9;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    tick();
    // Controls forced low while reset is held, even with a hazard present.
    set_load_use(5'd5, 5'd5, 5'd7, 3'b111);
    settle();
    check("rst_ctrl", 32'(ctrl), 32'(C_NONE));
    tick();
    rst = 1'b0;
    set_idle();
    settle();
    check("post_rst_ctrl", 32'(ctrl), 32'(C_NONE));
    check("post_rst_timeout", 32'(mdu_timeout), 32'd0);
    check("post_rst_cnt", 32'(stall_cycles), 32'd0);

    // 1: load-use on rs1, then released; x0 and qualifier variants.
    set_load_use(5'd5, 5'd5, 5'd7, 3'b111);
    settle();
    check("lu_rs1", 32'(ctrl), 32'(C_LU));
    tick();
    set_idle();
    EX_rd = 5'd6; EX_ValidReg = 3'b111;
    settle();
    check("lu_released", 32'(ctrl), 32'(C_NONE));
    check("lu_cnt", 32'(stall_cycles), 32'd1);
    set_load_use(5'd0, 5'd0, 5'd7, 3'b111);
    settle();
    check("lu_x0", 32'(ctrl), 32'(C_NONE));
    set_load_use(5'd5, 5'd1, 5'd5, 3'b111);
    settle();
    check("lu_rs2", 32'(ctrl), 32'(C_LU));
    set_load_use(5'd5, 5'd1, 5'd5, 3'b011);
    settle();
    check("lu_rs2_unread", 32'(ctrl), 32'(C_NONE));
    set_load_use(5'd5, 5'd5, 5'd7, 3'b111);
    EX_ValidReg = 3'b000;
    settle();
    check("lu_no_rd", 32'(ctrl), 32'(C_NONE));

    // 2: mul, done arrives in cycle 5; start only in cycle 0.
    do_reset();
    set_mul();
    settle();
    check("mdu_c0", 32'(ctrl), 32'(C_START));
    tick();
    for (int c = 1; c <= 4; c++) begin
      settle();
      check($sformatf("mdu_c%0d", c), 32'(ctrl), 32'(C_HOLD));
      tick();
    end
    mdu_done = 1'b1;
    settle();
    check("mdu_done_rel", 32'(ctrl), 32'(C_NONE));
    tick();
    set_idle();
    settle();
    check("mdu_cnt", 32'(stall_cycles), 32'd5);
    set_load_use(5'd5, 5'd5, 5'd7, 3'b111);
    settle();
    check("mdu_back_run", 32'(ctrl), 32'(C_LU));

    // 3: memory wait for 3 cycles, outranks load-use; no load-use on exit cycle.
    do_reset();
    set_load_use(5'd5, 5'd5, 5'd7, 3'b111);
    MEM_dmem_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("memw_c%0d", c), 32'(ctrl), 32'(C_MEMW));
      tick();
    end
    dmem_ready = 1'b1;
    settle();
    check("memw_release", 32'(ctrl), 32'(C_NONE));
    tick();
    MEM_dmem_req = 1'b0; dmem_ready = 1'b0;
    settle();
    check("memw_cnt", 32'(stall_cycles), 32'd3);
    check("memw_back_run", 32'(ctrl), 32'(C_LU));

    // 4: mdu_done lands during a memory wait and is remembered.
    do_reset();
    set_mul();
    settle();
    check("mix_start", 32'(ctrl), 32'(C_START));
    tick();
    settle();
    check("mix_hold", 32'(ctrl), 32'(C_HOLD));
    tick();
    MEM_dmem_req = 1'b1; mdu_done = 1'b1;
    settle();
    check("mix_memw0", 32'(ctrl), 32'(C_MEMW));
    tick();
    mdu_done = 1'b0;
    settle();
    check("mix_memw1", 32'(ctrl), 32'(C_MEMW));
    tick();
    dmem_ready = 1'b1;
    settle();
    check("mix_release", 32'(ctrl), 32'(C_NONE));
    tick();
    set_idle();
    settle();
    check("mix_after", 32'(ctrl), 32'(C_NONE));
    check("mix_cnt", 32'(stall_cycles), 32'd4);

    // 5: taken branch suppresses load-use.
    do_reset();
    set_load_use(5'd5, 5'd5, 5'd7, 3'b111);
    EX_branch_taken = 1'b1;
    settle();
    check("br_flush", 32'(ctrl), 32'(C_BR));
    tick();
    settle();
    check("br_cnt", 32'(stall_cycles), 32'd0);

    // 6: MDU never finishes; watchdog fires after MDU_TIMEOUT busy cycles.
    do_reset();
    set_mul();
    tick();
    for (int c = 1; c <= MDU_TIMEOUT; c++) begin
      settle();
      if (c == MDU_TIMEOUT) check("wd_before", 32'(mdu_timeout), 32'd0);
      tick();
    end
    settle();
    check("wd_fired", 32'(mdu_timeout), 32'd1);
    check("wd_still_hold", 32'(ctrl), 32'(C_HOLD));
    tick();
    settle();
    check("wd_sticky", 32'(mdu_timeout), 32'd1);
    rst = 1'b1;
    settle();
    check("wd_rst_ctrl", 32'(ctrl), 32'(C_NONE));
    tick();
    rst = 1'b0;
    set_idle();
    settle();
    check("wd_rst_flag", 32'(mdu_timeout), 32'd0);
    check("wd_rst_cnt", 32'(stall_cycles), 32'd0);
    check("wd_rst_ctrl2", 32'(ctrl), 32'(C_NONE));
    set_load_use(5'd5, 5'd5, 5'd7, 3'b111);
    settle();
    check("wd_rst_run", 32'(ctrl), 32'(C_LU));

    // Stall counter saturates at all-ones.
    do_reset();
    MEM_dmem_req = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    settle();
    check("cnt_sat", 32'(stall_cycles), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
